// File: rtl/rf_operand_fetch.sv
// Register-file operand fetch: issues RF reads, waits out the read latency and bypasses racing writebacks.
// Optional performance counters are enabled with `define RF_OPFETCH_PERF_EN.
module rf_operand_fetch #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [ADDR_WIDTH-1:0] rf_raddr1,
    output logic [ADDR_WIDTH-1:0] rf_raddr2,
    input  logic [DATA_WIDTH-1:0] rf_rdata1,
    input  logic [DATA_WIDTH-1:0] rf_rdata2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_src1,
    output logic [DATA_WIDTH-1:0] out_src2
`ifdef RF_OPFETCH_PERF_EN
    ,
    output logic [31:0]           perf_req_cnt,
    output logic [31:0]           perf_byp_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
    } state_t;

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] rs1, rs2;
    logic                  pend1, pend2;
    logic [DATA_WIDTH-1:0] pdata1, pdata2;
    logic                  wb_live;
    logic                  hit1, hit2;
    logic                  acc_hit1, acc_hit2;
    logic [DATA_WIDTH-1:0] fetch1, fetch2;

    // x0 writebacks are dropped entirely: no RF write and no bypass.
    assign wb_live  = wb_valid && (wb_rd != '0);
    assign hit1     = wb_live && (wb_rd == rs1);
    assign hit2     = wb_live && (wb_rd == rs2);
    assign acc_hit1 = wb_live && (wb_rd == in_rs1);
    assign acc_hit2 = wb_live && (wb_rd == in_rs2);

    assign rf_wen   = wb_live && !rst;
    assign rf_waddr = wb_rd;
    assign rf_wdata = wb_data;

    assign rf_raddr1 = (state == IDLE) ? in_rs1 : rs1;
    assign rf_raddr2 = (state == IDLE) ? in_rs2 : rs2;

    always_comb begin
        fetch1 = rf_rdata1;
        if (rs1 == '0)  fetch1 = '0;
        else if (hit1)  fetch1 = wb_data;
        else if (pend1) fetch1 = pdata1;
        fetch2 = rf_rdata2;
        if (rs2 == '0)  fetch2 = '0;
        else if (hit2)  fetch2 = wb_data;
        else if (pend2) fetch2 = pdata2;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = FETCH;
            end
            FETCH: state_nx = VALID;
            VALID: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rs1      <= '0;
            rs2      <= '0;
            pend1    <= 1'b0;
            pend2    <= 1'b0;
            pdata1   <= '0;
            pdata2   <= '0;
            out_src1 <= '0;
            out_src2 <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        rs1    <= in_rs1;
                        rs2    <= in_rs2;
                        pend1  <= acc_hit1;
                        pend2  <= acc_hit2;
                        pdata1 <= wb_data;
                        pdata2 <= wb_data;
                    end
                end
                FETCH: begin
                    out_src1 <= fetch1;
                    out_src2 <= fetch2;
                    pend1    <= 1'b0;
                    pend2    <= 1'b0;
                end
                VALID: begin
                    if (hit1) out_src1 <= wb_data;
                    if (hit2) out_src2 <= wb_data;
                end
                default: ;
            endcase
        end
    end

`ifdef RF_OPFETCH_PERF_EN
    logic byp_edge;

    assign byp_edge = ((state == FETCH) && (hit1 || hit2 || pend1 || pend2)) ||
                      ((state == VALID) && (hit1 || hit2));

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_req_cnt <= '0;
            perf_byp_cnt <= '0;
        end else begin
            if (out_valid && out_ready) perf_req_cnt <= perf_req_cnt + 32'd1;
            if (byp_edge)               perf_byp_cnt <= perf_byp_cnt + 32'd1;
        end
    end
`endif

endmodule
